mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer that shares one single-port, fixed-latency unified memory between the pipelined CPU's instruction-fetch (IF) stage and data-memory (MEM) stage. It issues one memory transaction at a time, returns read data and completion pulses to each requester, and drives per-stage stall outputs that freeze the pipeline while a stage's access is outstanding. Data accesses have priority over fetch. A streak counter bounds how long fetch can be starved.

## Interface
- MEM_LAT, 2: cycles from the `o_mem_en` cycle to valid `i_mem_rdata`; legal range is 1..15.
- MAX_STREAK, 3: maximum consecutive DM grants while IF is waiting; legal range is 1..15.
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_if_req  in  1  fetch request; held high with a stable address until `o_if_valid`
- i_if_addr  in  32  fetch byte address
- o_if_gnt  out  1  one-cycle pulse when the fetch is granted
- o_if_valid  out  1  one-cycle completion pulse; `o_if_rdata` is valid in this cycle
- o_if_rdata  out  32  fetched word; holds its value until the next IF completion
- i_dm_req  in  1  data request; held high with stable `addr`/`we`/`wdata` until `o_dm_valid`
- i_dm_we  in  1  1 = write, 0 = read
- i_dm_addr  in  32  data byte address
- i_dm_wdata  in  32  write data
- o_dm_gnt  out  1  one-cycle grant pulse
- o_dm_valid  out  1  one-cycle completion pulse, for reads and writes
- o_dm_rdata  out  32  read word; unchanged by writes
- o_stall_if  out  1  `i_if_req & ~o_if_valid`
- o_stall_mem  out  1  `i_dm_req & ~o_dm_valid`
- o_mem_en  out  1  memory command strobe (one cycle per transaction)
- o_mem_we  out  1  memory write enable; qualified by `o_mem_en`
- o_mem_addr  out  32  memory address; registered
- o_mem_wdata  out  32  memory write data; registered
- i_mem_rdata  in  32  memory read data; valid MEM_LAT cycles after the `o_mem_en` cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. There is also an owner register (IF or DM).
- IDLE
  - With no request, the FSM stays in IDLE.
  - Otherwise it selects a winner combinationally and pulses that requester's `o_*_gnt` in the same cycle.
  - It latches the address, write data and write enable (write enable is 0 for IF) into the `o_mem_*` registers, then moves to ISSUE.
- Winner selection:
  - DM wins when both request, unless `streak == MAX_STREAK`; then IF wins.
- Streak counter (4-bit):
  - Increments on a DM grant while `i_if_req = 1`.
  - Clears on any IF grant, or on a DM grant with `i_if_req = 0`.
  - Saturates at MAX_STREAK.
- ISSUE: `o_mem_en = 1` for exactly this cycle. Next state is WAIT, with the latency counter loaded with MEM_LAT.
- WAIT
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, read data is captured at the clock edge into the owner's rdata register.
  - The capture happens only for reads. For IF or for a DM read, that means `o_if_rdata` or `o_dm_rdata`; DM writes capture nothing.
  - Next state is DONE.
- DONE: pulse the owner's `o_*_valid` for one cycle. No grant is made in this cycle. Next state is IDLE.
- Requesters may drop or change their request in the DONE cycle. The arbiter does not sample requests in DONE.
- Changes to request inputs while a transaction is outstanding are ignored, because address and data are already registered.
- Reset (synchronous, any state):
  - All outputs go to 0, including both rdata registers and all `o_mem_*` outputs.
  - State returns to IDLE; streak and latency counters are 0.
  - An in-flight transaction is abandoned, with no valid pulse and no late capture.
  - A write already strobed by `o_mem_en` is not undone.

## Timing
- Grant in cycle T → `o_mem_en` in T+1 → `i_mem_rdata` sampled at the end of T+1+MEM_LAT → `o_*_valid` in T+2+MEM_LAT.
- The earliest next grant is T+3+MEM_LAT. With the default MEM_LAT = 2, a grant at T gives valid at T+4 and the next grant at T+5.
- Throughput: one transaction per MEM_LAT+3 cycles. Memory is never strobed twice in one transaction.
- The stall outputs are combinational from requests and the valid pulses. Stall is low in the valid cycle, so the stage advances on that edge.
- Reset values: every output is 0. With no requests after reset, no output toggles.

## Test plan
- IF-only read: reset, then `i_if_req = 1`, `i_if_addr = 0x0000_0010` at cycle 1, memory returning `0xDEAD_BEEF`.
  - Expect `o_if_gnt` at cycle 1, `o_mem_en` at cycle 2 with addr 0x10 and we = 0, and `o_if_valid` at cycle 5 with `o_if_rdata = 0xDEAD_BEEF`.
  - Expect `o_stall_if` high during cycles 1–4.
- Simultaneous request: IF (0x20) and DM read (0x100) both asserted at cycle 1.
  - Expect DM granted at cycle 1 with `o_dm_valid` at cycle 5.
  - Expect IF granted at cycle 6 with `o_if_valid` at cycle 10.
  - Expect `o_stall_if` high during cycles 1–9.
- DM write: `i_dm_we = 1`, addr 0x40, wdata 0x1234_5678.
  - Expect `o_mem_en = o_mem_we = 1` with matching addr and data for exactly one cycle.
  - Expect `o_dm_valid` 3 cycles later and `o_dm_rdata` unchanged.
- Starvation bound (MAX_STREAK = 3): DM requests back to back and IF is held high.
  - Expect exactly 3 DM grants, then an IF grant, then DM again.
- Reset mid-WAIT: assert `i_rst_n = 0` for one cycle during WAIT of an IF read.
  - Expect no `o_if_valid`, all outputs 0, and `o_if_rdata` remaining 0.
  - A new request after reset follows the normal timing.
- MEM_LAT = 1 and MEM_LAT = 15 builds: repeat the IF-only read.
  - Expect valid at T+3 and T+17 respectively.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals seen by mem_port_arbiter.
// Signal names keep the arbiter's point of view (i_ = into the arbiter, o_ = out of it).
interface mem_port_arbiter_if;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_valid;
    logic [31:0] o_if_rdata;

    logic        i_dm_req;
    logic        i_dm_we;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic        o_dm_gnt;
    logic        o_dm_valid;
    logic [31:0] o_dm_rdata;

    logic        o_stall_if;
    logic        o_stall_mem;

    logic        o_mem_en;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_mem_rdata,
        output o_if_gnt, o_if_valid, o_if_rdata, o_dm_gnt, o_dm_valid, o_dm_rdata,
        output o_stall_if, o_stall_mem, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_mem_rdata,
        input  o_if_gnt, o_if_valid, o_if_rdata, o_dm_gnt, o_dm_valid, o_dm_rdata,
        input  o_stall_if, o_stall_mem, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the IF and MEM stages, one transaction at a
// time, with data-side priority and a bounded streak so fetch cannot starve forever.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);
    localparam logic [3:0] MAX4 = 4'(MAX_STREAK);

    state_t      r_state;
    state_t      w_next;
    owner_t      r_owner;
    logic [3:0]  r_streak;
    logic [3:0]  r_lat;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        w_dm_win;
    logic        w_if_win;
    logic        w_if_valid;
    logic        w_dm_valid;

    always_comb begin
        w_next   = r_state;
        w_dm_win = 1'b0;
        w_if_win = 1'b0;
        case (r_state)
            IDLE: begin
                // Grants are suppressed while reset is held so every output reads 0.
                if (i_rst_n) begin
                    if (bus.i_dm_req && !(bus.i_if_req && (r_streak == MAX4)))
                        w_dm_win = 1'b1;
                    else if (bus.i_if_req)
                        w_if_win = 1'b1;
                    if (bus.i_dm_req || bus.i_if_req)
                        w_next = ISSUE;
                end
            end
            ISSUE:   w_next = WAIT;
            WAIT:    if (r_lat == 4'd1) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_streak    <= 4'd0;
            r_lat       <= 4'd0;
            r_if_rdata  <= 32'd0;
            r_dm_rdata  <= 32'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_dm_win) begin
                r_owner     <= OWN_DM;
                r_mem_we    <= bus.i_dm_we;
                r_mem_addr  <= bus.i_dm_addr;
                r_mem_wdata <= bus.i_dm_wdata;
                if (!bus.i_if_req)
                    r_streak <= 4'd0;
                else if (r_streak < MAX4)
                    r_streak <= r_streak + 4'd1;
            end else if (w_if_win) begin
                r_owner     <= OWN_IF;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.i_if_addr;
                r_mem_wdata <= 32'd0;
                r_streak    <= 4'd0;
            end
            if (r_state == ISSUE) begin
                r_lat <= LAT4;
            end else if (r_state == WAIT) begin
                r_lat <= r_lat - 4'd1;
                // Memory data is valid in the last WAIT cycle; writes leave rdata alone.
                if ((r_lat == 4'd1) && !r_mem_we) begin
                    if (r_owner == OWN_IF)
                        r_if_rdata <= bus.i_mem_rdata;
                    else
                        r_dm_rdata <= bus.i_mem_rdata;
                end
            end
        end
    end

    assign w_if_valid = (r_state == DONE) && (r_owner == OWN_IF);
    assign w_dm_valid = (r_state == DONE) && (r_owner == OWN_DM);

    assign bus.o_if_gnt    = w_if_win;
    assign bus.o_dm_gnt    = w_dm_win;
    assign bus.o_if_valid  = w_if_valid;
    assign bus.o_dm_valid  = w_dm_valid;
    assign bus.o_if_rdata  = r_if_rdata;
    assign bus.o_dm_rdata  = r_dm_rdata;
    assign bus.o_stall_if  = bus.i_if_req & ~w_if_valid;
    assign bus.o_stall_mem = bus.i_dm_req & ~w_dm_valid;
    assign bus.o_mem_en    = (r_state == ISSUE);
    assign bus.o_mem_we    = r_mem_we;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance carries most scenarios,
// MEM_LAT=1 and MEM_LAT=15 instances repeat the fetch-only read.
module tb_mem_port_arbiter;

    logic clk;
    logic rstN;
    int   total;
    int   bad;

    mem_port_arbiter_if b ();
    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b15 ();

    mem_port_arbiter #(.MEM_LAT(2), .MAX_STREAK(3)) dut (
        .i_clk(clk), .i_rst_n(rstN), .bus(b));
    mem_port_arbiter #(.MEM_LAT(1), .MAX_STREAK(3)) dut1 (
        .i_clk(clk), .i_rst_n(rstN), .bus(b1));
    mem_port_arbiter #(.MEM_LAT(15), .MAX_STREAK(3)) dut15 (
        .i_clk(clk), .i_rst_n(rstN), .bus(b15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: 0x10 holds DEADBEEF, every other word is {addr[15:0], C0DE}.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0], 16'hC0DE};
    endfunction

    // Each memory drives valid data only in the cycle exactly LAT cycles after its strobe.
    logic [4:0]  since0, since1, since15;
    logic [31:0] addr0, addr1, addr15;

    always @(posedge clk) begin
        if (!rstN) since0 <= 5'd0;
        else if (b.o_mem_en) begin since0 <= 5'd1; addr0 <= b.o_mem_addr; end
        else if (since0 != 5'd0 && since0 != 5'd31) since0 <= since0 + 5'd1;
    end
    always @(posedge clk) begin
        if (!rstN) since1 <= 5'd0;
        else if (b1.o_mem_en) begin since1 <= 5'd1; addr1 <= b1.o_mem_addr; end
        else if (since1 != 5'd0 && since1 != 5'd31) since1 <= since1 + 5'd1;
    end
    always @(posedge clk) begin
        if (!rstN) since15 <= 5'd0;
        else if (b15.o_mem_en) begin since15 <= 5'd1; addr15 <= b15.o_mem_addr; end
        else if (since15 != 5'd0 && since15 != 5'd31) since15 <= since15 + 5'd1;
    end

    assign b.i_mem_rdata   = (since0 == 5'd2)   ? memf(addr0)  : 32'hBAD0_BAD0;
    assign b1.i_mem_rdata  = (since1 == 5'd1)   ? memf(addr1)  : 32'hBAD0_BAD0;
    assign b15.i_mem_rdata = (since15 == 5'd15) ? memf(addr15) : 32'hBAD0_BAD0;

    logic [135:0] allOut0, allOut1, allOut15;
    assign allOut0 = {b.o_if_gnt, b.o_if_valid, b.o_if_rdata, b.o_dm_gnt, b.o_dm_valid,
                      b.o_dm_rdata, b.o_stall_if, b.o_stall_mem, b.o_mem_en, b.o_mem_we,
                      b.o_mem_addr, b.o_mem_wdata};
    assign allOut1 = {b1.o_if_gnt, b1.o_if_valid, b1.o_if_rdata, b1.o_dm_gnt, b1.o_dm_valid,
                      b1.o_dm_rdata, b1.o_stall_if, b1.o_stall_mem, b1.o_mem_en, b1.o_mem_we,
                      b1.o_mem_addr, b1.o_mem_wdata};
    assign allOut15 = {b15.o_if_gnt, b15.o_if_valid, b15.o_if_rdata, b15.o_dm_gnt,
                       b15.o_dm_valid, b15.o_dm_rdata, b15.o_stall_if, b15.o_stall_mem,
                       b15.o_mem_en, b15.o_mem_we, b15.o_mem_addr, b15.o_mem_wdata};

    // Reset with idle inputs, then confirm nothing toggles while no one requests.
    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (allOut0 !== 136'd0) begin bad++; $display("[TB] FAIL reset_out0: got %h want 0", allOut0); end
        total++;
        if (allOut1 !== 136'd0) begin bad++; $display("[TB] FAIL reset_out1: got %h want 0", allOut1); end
        total++;
        if (allOut15 !== 136'd0) begin bad++; $display("[TB] FAIL reset_out15: got %h want 0", allOut15); end
        @(posedge clk); #1;
        rstN = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if (allOut0 !== 136'd0) begin bad++; $display("[TB] FAIL idle_out c=%0d: got %h want 0", c, allOut0); end
            @(posedge clk); #1;
        end
    endtask

    // Fetch-only read of 0x10 on all three latency builds in parallel.
    task automatic test_if_read();
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            b.i_if_req   = (c <= 5);
            b1.i_if_req  = (c <= 4);
            b15.i_if_req = (c <= 18);
            b.i_if_addr  = 32'h10;
            b1.i_if_addr = 32'h10;
            b15.i_if_addr = 32'h10;
            @(negedge clk);
            total++;
            if (b.o_if_gnt !== (c == 1)) begin bad++; $display("[TB] FAIL if_gnt c=%0d: got %b want %b", c, b.o_if_gnt, c == 1); end
            total++;
            if (b.o_mem_en !== (c == 2)) begin bad++; $display("[TB] FAIL if_mem_en c=%0d: got %b want %b", c, b.o_mem_en, c == 2); end
            total++;
            if (b.o_if_valid !== (c == 5)) begin bad++; $display("[TB] FAIL if_valid c=%0d: got %b want %b", c, b.o_if_valid, c == 5); end
            total++;
            if (b.o_stall_if !== (c <= 4)) begin bad++; $display("[TB] FAIL if_stall c=%0d: got %b want %b", c, b.o_stall_if, c <= 4); end
            total++;
            if (b1.o_if_valid !== (c == 4)) begin bad++; $display("[TB] FAIL lat1_valid c=%0d: got %b want %b", c, b1.o_if_valid, c == 4); end
            total++;
            if (b15.o_if_valid !== (c == 18)) begin bad++; $display("[TB] FAIL lat15_valid c=%0d: got %b want %b", c, b15.o_if_valid, c == 18); end
            if (c == 2) begin
                total++;
                if (b.o_mem_addr !== 32'h10) begin bad++; $display("[TB] FAIL if_mem_addr: got %h want 00000010", b.o_mem_addr); end
                total++;
                if (b.o_mem_we !== 1'b0) begin bad++; $display("[TB] FAIL if_mem_we: got %b want 0", b.o_mem_we); end
            end
            if (c == 5) begin
                total++;
                if (b.o_if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL if_rdata: got %h want deadbeef", b.o_if_rdata); end
            end
            if (c == 4) begin
                total++;
                if (b1.o_if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL lat1_rdata: got %h want deadbeef", b1.o_if_rdata); end
            end
            if (c == 18) begin
                total++;
                if (b15.o_if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL lat15_rdata: got %h want deadbeef", b15.o_if_rdata); end
            end
        end
        @(posedge clk); #1;
    endtask

    // IF 0x20 and DM read 0x100 together: DM goes first, IF follows after one idle gap.
    task automatic test_simultaneous();
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            b.i_if_req  = (c <= 10);
            b.i_if_addr = 32'h20;
            b.i_dm_req  = (c <= 5);
            b.i_dm_we   = 1'b0;
            b.i_dm_addr = 32'h100;
            @(negedge clk);
            total++;
            if (b.o_dm_gnt !== (c == 1)) begin bad++; $display("[TB] FAIL sim_dm_gnt c=%0d: got %b want %b", c, b.o_dm_gnt, c == 1); end
            total++;
            if (b.o_if_gnt !== (c == 6)) begin bad++; $display("[TB] FAIL sim_if_gnt c=%0d: got %b want %b", c, b.o_if_gnt, c == 6); end
            total++;
            if (b.o_dm_valid !== (c == 5)) begin bad++; $display("[TB] FAIL sim_dm_valid c=%0d: got %b want %b", c, b.o_dm_valid, c == 5); end
            total++;
            if (b.o_if_valid !== (c == 10)) begin bad++; $display("[TB] FAIL sim_if_valid c=%0d: got %b want %b", c, b.o_if_valid, c == 10); end
            total++;
            if (b.o_stall_if !== (c <= 9)) begin bad++; $display("[TB] FAIL sim_stall_if c=%0d: got %b want %b", c, b.o_stall_if, c <= 9); end
            total++;
            if (b.o_stall_mem !== (c <= 4)) begin bad++; $display("[TB] FAIL sim_stall_mem c=%0d: got %b want %b", c, b.o_stall_mem, c <= 4); end
            if (c == 5) begin
                total++;
                if (b.o_dm_rdata !== 32'h0100_C0DE) begin bad++; $display("[TB] FAIL sim_dm_rdata: got %h want 0100c0de", b.o_dm_rdata); end
            end
            if (c == 10) begin
                total++;
                if (b.o_if_rdata !== 32'h0020_C0DE) begin bad++; $display("[TB] FAIL sim_if_rdata: got %h want 0020c0de", b.o_if_rdata); end
            end
        end
        @(posedge clk); #1;
        b.i_if_req = 1'b0;
    endtask

    // DM write of 0x12345678 to 0x40: one strobe, valid three cycles later, rdata untouched.
    task automatic test_dm_write();
        int enCount;
        enCount = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            b.i_dm_req   = (c <= 5);
            b.i_dm_we    = 1'b1;
            b.i_dm_addr  = 32'h40;
            b.i_dm_wdata = 32'h1234_5678;
            @(negedge clk);
            if (b.o_mem_en) enCount++;
            total++;
            if (b.o_mem_en !== (c == 2)) begin bad++; $display("[TB] FAIL wr_mem_en c=%0d: got %b want %b", c, b.o_mem_en, c == 2); end
            total++;
            if (b.o_dm_valid !== (c == 5)) begin bad++; $display("[TB] FAIL wr_valid c=%0d: got %b want %b", c, b.o_dm_valid, c == 5); end
            if (c == 2) begin
                total++;
                if ({b.o_mem_we, b.o_mem_addr, b.o_mem_wdata} !== {1'b1, 32'h40, 32'h1234_5678}) begin
                    bad++;
                    $display("[TB] FAIL wr_cmd: got we=%b addr=%h data=%h want we=1 addr=00000040 data=12345678", b.o_mem_we, b.o_mem_addr, b.o_mem_wdata);
                end
            end
            if (c >= 5) begin
                total++;
                if (b.o_dm_rdata !== 32'h0100_C0DE) begin bad++; $display("[TB] FAIL wr_rdata c=%0d: got %h want 0100c0de", c, b.o_dm_rdata); end
            end
        end
        total++;
        if (enCount != 1) begin bad++; $display("[TB] FAIL wr_en_count: got %0d want 1", enCount); end
        b.i_dm_we    = 1'b0;
        b.i_dm_wdata = 32'd0;
    endtask

    // DM back to back with IF held: three DM grants, one IF grant, then DM again.
    task automatic test_starvation();
        byte got [5];
        byte exp [5];
        int  n;
        exp = '{"D", "D", "D", "I", "D"};
        got = '{"-", "-", "-", "-", "-"};
        n   = 0;
        for (int c = 1; c <= 60 && n < 5; c++) begin
            @(posedge clk); #1;
            b.i_if_req  = 1'b1;
            b.i_if_addr = 32'h30;
            b.i_dm_req  = 1'b1;
            b.i_dm_we   = 1'b0;
            b.i_dm_addr = 32'h200;
            @(negedge clk);
            if (b.o_dm_gnt && b.o_if_gnt) begin
                bad++;
                $display("[TB] FAIL starve_double_gnt c=%0d: got both grants want one", c);
            end
            if (b.o_dm_gnt) begin got[n] = "D"; n++; end
            else if (b.o_if_gnt) begin got[n] = "I"; n++; end
        end
        total++;
        if (n != 5) begin bad++; $display("[TB] FAIL starve_budget: got %0d grants want 5", n); end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got[k] !== exp[k]) begin bad++; $display("[TB] FAIL starve_seq[%0d]: got %c want %c", k, got[k], exp[k]); end
        end
        @(posedge clk); #1;
        b.i_if_req = 1'b0;
        b.i_dm_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Reset pulse in the middle of an IF read: no completion, no late capture, clean restart.
    task automatic test_reset_mid_wait();
        rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            rstN        = (c != 3);
            b.i_if_req  = (c <= 2) || (c >= 9 && c <= 12);
            b.i_if_addr = 32'h10;
            @(negedge clk);
            total++;
            if (b.o_if_gnt !== (c == 1 || c == 9)) begin bad++; $display("[TB] FAIL rst_if_gnt c=%0d: got %b want %b", c, b.o_if_gnt, c == 1 || c == 9); end
            total++;
            if (b.o_mem_en !== (c == 2 || c == 10)) begin bad++; $display("[TB] FAIL rst_mem_en c=%0d: got %b want %b", c, b.o_mem_en, c == 2 || c == 10); end
            total++;
            if (b.o_if_valid !== (c == 13)) begin bad++; $display("[TB] FAIL rst_if_valid c=%0d: got %b want %b", c, b.o_if_valid, c == 13); end
            if (c >= 4 && c <= 8) begin
                total++;
                if (allOut0 !== 136'd0) begin bad++; $display("[TB] FAIL rst_all_zero c=%0d: got %h want 0", c, allOut0); end
            end
            if (c == 13) begin
                total++;
                if (b.o_if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL rst_if_rdata: got %h want deadbeef", b.o_if_rdata); end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        b.i_if_req = 1'b0;   b.i_if_addr = 32'd0;   b.i_dm_req = 1'b0;
        b.i_dm_we = 1'b0;    b.i_dm_addr = 32'd0;   b.i_dm_wdata = 32'd0;
        b1.i_if_req = 1'b0;  b1.i_if_addr = 32'd0;  b1.i_dm_req = 1'b0;
        b1.i_dm_we = 1'b0;   b1.i_dm_addr = 32'd0;  b1.i_dm_wdata = 32'd0;
        b15.i_if_req = 1'b0; b15.i_if_addr = 32'd0; b15.i_dm_req = 1'b0;
        b15.i_dm_we = 1'b0;  b15.i_dm_addr = 32'd0; b15.i_dm_wdata = 32'd0;
        test_reset();
        test_if_read();
        test_simultaneous();
        test_dm_write();
        test_starvation();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
